display_source_arbiter: RTL and testbench

Shares the 4-digit 7-segment display between two independent requesters, each presenting a 16-bit hex value and 4 decimal-point flags.
- Grants ownership round-robin, with a guaranteed minimum hold time per grant.
- Converts the owner's value into active-low segment bytes (a b c d e f g DP).
- Drives the per-digit segment inputs of the LED display controller.
- Blanks the display when no requester owns it.

---
 rtl/display_pkg.sv | 30 +++
 rtl/display_source_arbiter_hex7seg_encoder.sv | 12 +
 rtl/display_source_arbiter.sv | 154 +++++++++++++++
 tb/tb_display_source_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the display source arbiter
package display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Active-low {a,b,c,d,e,f,g}; element [n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/display_source_arbiter_hex7seg_encoder.sv
// rtl/display_source_arbiter_hex7seg_encoder.sv - nibble plus decimal point to active-low segment byte
module hex7seg_encoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {HEX_SEG_TABLE[nibble], ~dp};

endmodule

// File: rtl/display_source_arbiter.sv
// rtl/display_source_arbiter.sv - round-robin owner of the 4-digit display with minimum hold per grant
module display_source_arbiter
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = 25000000,
  parameter int HOLD_WIDTH  = 25
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req0,
  input  logic [15:0] i_value0,
  input  logic [3:0]  i_dp0,
  input  logic        i_req1,
  input  logic [15:0] i_value1,
  input  logic [3:0]  i_dp1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic [7:0]  o_display_D0,
  output logic [7:0]  o_display_D1,
  output logic [7:0]  o_display_D2,
  output logic [7:0]  o_display_D3
);

  localparam logic [HOLD_WIDTH-1:0] HOLD_RELOAD = HOLD_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE    = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state, state_nx;
  logic [HOLD_WIDTH-1:0] hold_cnt, hold_nx;
  logic                  last_owner, last_nx;
  logic                  gnt0_nx, gnt1_nx;
  logic [3:0][7:0]       disp_q, disp_nx;
  logic                  hold_done;

  logic                  src_sel;
  logic [15:0]           src_value;
  logic [3:0]            src_dp;
  logic [3:0][7:0]       src_seg;

  assign hold_done = (hold_cnt == '0);

  // Which requester's value feeds the encoders this cycle: the one being granted or the current owner.
  always_comb begin
    src_sel = 1'b0;
    case (state)
      ST_IDLE: src_sel = i_req1 && (!i_req0 || !last_owner);
      ST_OWN0: src_sel = hold_done && i_req1;
      ST_OWN1: src_sel = !(hold_done && i_req0);
      default: src_sel = 1'b0;
    endcase
  end

  assign src_value = src_sel ? i_value1 : i_value0;
  assign src_dp    = src_sel ? i_dp1    : i_dp0;

  for (genvar n = 0; n < 4; n++) begin : g_enc
    hex7seg_encoder u_enc (
      .nibble (src_value[4*n +: 4]),
      .dp     (src_dp[n]),
      .seg    (src_seg[n])
    );
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    last_nx  = last_owner;
    gnt0_nx  = o_gnt0;
    gnt1_nx  = o_gnt1;
    disp_nx  = disp_q;
    case (state)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          state_nx = src_sel ? ST_OWN1 : ST_OWN0;
          gnt0_nx  = !src_sel;
          gnt1_nx  = src_sel;
          hold_nx  = HOLD_RELOAD;
          disp_nx  = src_seg;
          last_nx  = src_sel;
        end
      end
      ST_OWN0: begin
        if (!hold_done) begin
          hold_nx = hold_cnt - HOLD_ONE;
          if (i_req0) disp_nx = src_seg;
        end else if (i_req1) begin
          state_nx = ST_OWN1;
          gnt0_nx  = 1'b0;
          gnt1_nx  = 1'b1;
          hold_nx  = HOLD_RELOAD;
          disp_nx  = src_seg;
          last_nx  = 1'b1;
        end else if (!i_req0) begin
          state_nx = ST_IDLE;
          gnt0_nx  = 1'b0;
          gnt1_nx  = 1'b0;
          disp_nx  = {4{SEG_BLANK}};
        end else begin
          disp_nx = src_seg;
        end
      end
      ST_OWN1: begin
        if (!hold_done) begin
          hold_nx = hold_cnt - HOLD_ONE;
          if (i_req1) disp_nx = src_seg;
        end else if (i_req0) begin
          state_nx = ST_OWN0;
          gnt0_nx  = 1'b1;
          gnt1_nx  = 1'b0;
          hold_nx  = HOLD_RELOAD;
          disp_nx  = src_seg;
          last_nx  = 1'b0;
        end else if (!i_req1) begin
          state_nx = ST_IDLE;
          gnt0_nx  = 1'b0;
          gnt1_nx  = 1'b0;
          disp_nx  = {4{SEG_BLANK}};
        end else begin
          disp_nx = src_seg;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        hold_nx  = '0;
        disp_nx  = {4{SEG_BLANK}};
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      o_gnt0     <= 1'b0;
      o_gnt1     <= 1'b0;
      disp_q     <= {4{SEG_BLANK}};
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_nx;
      last_owner <= last_nx;
      o_gnt0     <= gnt0_nx;
      o_gnt1     <= gnt1_nx;
      disp_q     <= disp_nx;
    end
  end

  assign o_display_D0 = disp_q[0];
  assign o_display_D1 = disp_q[1];
  assign o_display_D2 = disp_q[2];
  assign o_display_D3 = disp_q[3];

endmodule

// File: tb/tb_display_source_arbiter.sv
// tb/tb_display_source_arbiter.sv - directed bench for display_source_arbiter with HOLD_CYCLES=4
module tb_display_source_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] value0, value1;
  logic [3:0]  dp0, dp1;
  logic        gnt0, gnt1;
  logic [7:0]  d0, d1, d2, d3;

  int checks   = 0;
  int failures = 0;

  display_source_arbiter #(.HOLD_CYCLES(4), .HOLD_WIDTH(25)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_req0       (req0),
    .i_value0     (value0),
    .i_dp0        (dp0),
    .i_req1       (req1),
    .i_value1     (value1),
    .i_dp1        (dp1),
    .o_gnt0       (gnt0),
    .o_gnt1       (gnt1),
    .o_display_D0 (d0),
    .o_display_D1 (d1),
    .o_display_D2 (d2),
    .o_display_D3 (d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic g0, input logic g1,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, "_gnt"}, {30'd0, gnt0, gnt1}, {30'd0, g0, g1});
    chk({tag, "_disp"}, {d3, d2, d1, d0}, {e3, e2, e1, e0});
  endtask

  initial begin
    rst_n  = 1'b0;
    req0   = 1'b0;
    req1   = 1'b0;
    value0 = 16'h0000;
    value1 = 16'h0000;
    dp0    = 4'b0000;
    dp1    = 4'b0000;
    tick(2);
    chk_state("reset", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    rst_n = 1'b1;
    tick(2);
    chk_state("idle_after_reset", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Single requester, then live tracking of a value change
    req0   = 1'b1;
    value0 = 16'h1234;
    dp0    = 4'b0001;
    tick(1);
    chk_state("single_1234", 1'b1, 1'b0, 8'b10011000, 8'b00001101, 8'b00100101, 8'b10011111);
    value0 = 16'h0000;
    tick(1);
    chk_state("single_0000", 1'b1, 1'b0, 8'b00000010, 8'b00000011, 8'b00000011, 8'b00000011);

    // Asynchronous reset in the middle of a grant
    rst_n = 1'b0;
    req0  = 1'b0;
    #1;
    chk_state("async_reset", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk_state("post_reset_idle", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Tie from reset: requester 0 first, alternate every 4 cycles
    value0 = 16'h1234;
    dp0    = 4'b0001;
    value1 = 16'hFFFF;
    dp1    = 4'b0000;
    req0   = 1'b1;
    req1   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_state($sformatf("tie_own0_%0d", i), 1'b1, 1'b0,
                8'b10011000, 8'b00001101, 8'b00100101, 8'b10011111);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_state($sformatf("tie_own1_%0d", i), 1'b0, 1'b1,
                8'b01110001, 8'b01110001, 8'b01110001, 8'b01110001);
    end
    tick(1);
    chk("tie_back_to_0", {30'd0, gnt0, gnt1}, 32'd2);
    req0 = 1'b0;
    req1 = 1'b0;
    tick(4);
    chk_state("tie_release", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // One-cycle pulse on requester 1 earns a full grant
    req1 = 1'b1;
    tick(1);
    req1   = 1'b0;
    value1 = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      chk_state($sformatf("pulse_own1_%0d", i), 1'b0, 1'b1,
                8'b01110001, 8'b01110001, 8'b01110001, 8'b01110001);
      tick(1);
    end
    chk_state("pulse_idle", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Owner drops its request early; grant persists with frozen segments
    value0 = 16'h1234;
    dp0    = 4'b0000;
    req0   = 1'b1;
    tick(1);
    chk_state("drop_c1", 1'b1, 1'b0, 8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111);
    value0 = 16'h0000;
    tick(1);
    chk_state("drop_c2", 1'b1, 1'b0, 8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011);
    req0   = 1'b0;
    value0 = 16'h8888;
    tick(1);
    chk_state("drop_c3", 1'b1, 1'b0, 8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011);
    tick(1);
    chk_state("drop_c4", 1'b1, 1'b0, 8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011);
    tick(1);
    chk_state("drop_idle", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Continuous owner keeps the display while nobody else asks
    value0 = 16'h0000;
    dp0    = 4'b0000;
    req0   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      chk($sformatf("cont_gnt_%0d", i), {30'd0, gnt0, gnt1}, 32'd2);
    end
    chk("cont_disp", {d3, d2, d1, d0}, {4{8'b00000011}});
    req0 = 1'b0;
    tick(1);
    chk_state("cont_idle", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
